// File: rtl/brick_hit_detector.sv
// Collision stage for the brick wall: keeps the alive mask, checks the ball's four
// corners one per cycle against a mask snapshot and kills at most one brick per check.
module brick_hit_detector #(
  parameter int NUM_COLS  = 10,
  parameter int NUM_ROWS  = 4,
  parameter int BRICK_W   = 16,
  parameter int ROW_PITCH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load_all,
  input  logic       start,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [5:0] hit_index,
  output logic [7:0] hit_x,
  output logic [6:0] hit_y,
  output logic       flip_x,
  output logic       flip_y,
  output logic [5:0] bricks_left,
  output logic       all_clear
);

  localparam int TOTAL   = NUM_COLS * NUM_ROWS;
  localparam int COL_SH  = $clog2(BRICK_W);
  localparam int ROW_SH  = $clog2(ROW_PITCH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [7:0]         bx_r;
  logic [6:0]         by_r;
  logic [1:0]         corner_r;
  logic [3:0]         corner_hit_r;
  logic [TOTAL-1:0]   alive_r;
  logic [5:0]         bricks_left_r;
  logic               busy_r;
  logic               done_r;
  logic               hit_r;
  logic [5:0]         hit_index_r;
  logic [7:0]         hit_x_r;
  logic [6:0]         hit_y_r;
  logic               flip_x_r;
  logic               flip_y_r;
  logic               all_clear_r;

  logic [8:0]         cx_s;
  logic [7:0]         cy_s;
  logic [3:0]         col_s;
  logic [3:0]         row_s;
  logic               on_brick_s;
  logic [5:0]         idx_s;
  logic [63:0]        alive_pad_s;
  logic               corner_live_s;
  logic [3:0]         hit_vec_s;
  logic               hit_any_s;
  logic               flip_x_s;
  logic [TOTAL-1:0]   one_hot_s;
  logic               kill_s;
  logic [TOTAL-1:0]   alive_next_s;
  logic [5:0]         bricks_next_s;

  // Next-state logic; load_all overrides everything and forces IDLE
  always_comb begin
    state_s = state_r;
    if (load_all) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   if (start) state_s = ST_CHECK; else state_s = ST_IDLE;
        ST_CHECK:  if (corner_r == 2'd3) state_s = ST_REPORT; else state_s = ST_CHECK;
        ST_REPORT: state_s = ST_IDLE;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Current corner geometry; a carry out of the 9/8-bit sums means the corner is off-wall
  always_comb begin
    cx_s          = {1'b0, bx_r} + {8'd0, corner_r[0]};
    cy_s          = {1'b0, by_r} + {7'd0, corner_r[1]};
    col_s         = cx_s[COL_SH +: 4];
    row_s         = cy_s[ROW_SH +: 4];
    on_brick_s    = !cx_s[8] && !cy_s[7] && (col_s < 4'(NUM_COLS)) &&
                    (row_s < 4'(NUM_ROWS)) && !cy_s[2];
    idx_s         = (6'(row_s) * 6'(NUM_COLS)) + 6'(col_s);
    alive_pad_s   = {{(64-TOTAL){1'b0}}, alive_r};
    corner_live_s = on_brick_s && alive_pad_s[idx_s];
    hit_vec_s     = corner_hit_r | ({3'd0, corner_live_s} << corner_r);
    hit_any_s     = |hit_vec_s;
    flip_x_s      = (hit_vec_s == 4'b0101) || (hit_vec_s == 4'b1010);
  end

  // Mask and count update; the kill is applied only on the edge leaving REPORT
  always_comb begin
    one_hot_s     = {{(TOTAL-1){1'b0}}, 1'b1} << hit_index_r;
    kill_s        = hit_r && ((alive_r & one_hot_s) != {TOTAL{1'b0}}) &&
                    (bricks_left_r != 6'd0);
    alive_next_s  = alive_r;
    bricks_next_s = bricks_left_r;
    if (load_all) begin
      alive_next_s  = {TOTAL{1'b1}};
      bricks_next_s = 6'(TOTAL);
    end else if ((state_r == ST_REPORT) && kill_s) begin
      alive_next_s  = alive_r & ~one_hot_s;
      bricks_next_s = bricks_left_r - 6'd1;
    end else begin
      alive_next_s  = alive_r;
      bricks_next_s = bricks_left_r;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bx_r          <= 8'd0;
      by_r          <= 7'd0;
      corner_r      <= 2'd0;
      corner_hit_r  <= 4'd0;
      alive_r       <= {TOTAL{1'b1}};
      bricks_left_r <= 6'(TOTAL);
      all_clear_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      hit_r         <= 1'b0;
      hit_index_r   <= 6'd0;
      hit_x_r       <= 8'd0;
      hit_y_r       <= 7'd0;
      flip_x_r      <= 1'b0;
      flip_y_r      <= 1'b0;
    end else begin
      alive_r       <= alive_next_s;
      bricks_left_r <= bricks_next_s;
      all_clear_r   <= (bricks_next_s == 6'd0);
      busy_r        <= (state_s != ST_IDLE);
      done_r        <= !load_all && (state_r == ST_CHECK) && (corner_r == 2'd3);
      if (load_all) begin
        corner_r     <= 2'd0;
        corner_hit_r <= 4'd0;
        hit_r        <= 1'b0;
        hit_index_r  <= 6'd0;
        hit_x_r      <= 8'd0;
        hit_y_r      <= 7'd0;
        flip_x_r     <= 1'b0;
        flip_y_r     <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              bx_r         <= ball_x;
              by_r         <= ball_y;
              corner_r     <= 2'd0;
              corner_hit_r <= 4'd0;
              hit_r        <= 1'b0;
              hit_index_r  <= 6'd0;
              hit_x_r      <= 8'd0;
              hit_y_r      <= 7'd0;
              flip_x_r     <= 1'b0;
              flip_y_r     <= 1'b0;
            end
          end
          ST_CHECK: begin
            corner_r     <= corner_r + 2'd1;
            corner_hit_r <= hit_vec_s;
            // Only the first hitting corner in TL,TR,BL,BR order names the brick
            if (corner_live_s && (corner_hit_r == 4'd0)) begin
              hit_index_r <= idx_s;
              hit_x_r     <= {col_s, 4'd0};
              hit_y_r     <= {row_s, 3'd0};
            end
            if (corner_r == 2'd3) begin
              hit_r    <= hit_any_s;
              flip_x_r <= flip_x_s;
              flip_y_r <= hit_any_s && !flip_x_s;
            end
          end
          ST_REPORT: begin
            corner_r <= 2'd0;
          end
          default: begin
            corner_r <= 2'd0;
          end
        endcase
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign hit         = hit_r;
  assign hit_index   = hit_index_r;
  assign hit_x       = hit_x_r;
  assign hit_y       = hit_y_r;
  assign flip_x      = flip_x_r;
  assign flip_y      = flip_y_r;
  assign bricks_left = bricks_left_r;
  assign all_clear   = all_clear_r;

endmodule
